vector_loader: RTL and testbench
================================

VECTOR_LOADER -- requirements
Module: vector_loader

Interface
REQ-001 Parameter WORD_W, default 32, host input word width.
REQ-002 Parameter SIZE, default 256, packed entry width; SIZE SHALL be a multiple of WORD_W (LANES = SIZE/WORD_W, default 8).
REQ-003 Parameter AW, default 6, entry address width (64 entries).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-low reset.
REQ-006 start  in  1  begin a load session; sampled only in IDLE.
REQ-007 base_addr  in  AW  first entry address; latched on accepted start.
REQ-008 s_data  in  WORD_W  host word.
REQ-009 s_valid  in  1  s_data valid.
REQ-010 s_last  in  1  qualifies final word of the session.
REQ-011 s_ready  out  1  block accepts s_data this cycle.
REQ-012 data_out  out  SIZE  packed entry driven to the storage stage's data_in.
REQ-013 write_addr  out  AW  entry address driven to the storage stage's host_write_addr.
REQ-014 write_en  out  1  one-cycle entry write strobe.
REQ-015 en_read  out  1  one-cycle pulse that starts the storage stage's read sequence.
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 entry_count  out  AW+1  entries written this session (0..64).
REQ-018 overflow  out  1  sticky flag: 64 entries written without s_last.

Function
REQ-019 FSM states: IDLE, FILL, WRITE, DONE; all outputs registered.
REQ-020 IDLE: s_ready=0; start=1 -> latch base_addr, clear entry_count, overflow, lane counter, and pack register; go to FILL next cycle.
REQ-021 FILL: s_ready=1; a beat is accepted when s_valid&s_ready; word k of an entry goes to bits [k*WORD_W +: WORD_W], lane 0 = LSBs.
REQ-022 FILL -> WRITE on the cycle after the beat filling lane LANES-1, or after any beat with s_last=1.
REQ-023 Partial entry (s_last before lane LANES-1): unfilled upper lanes SHALL be zero.
REQ-024 WRITE: write_en=1 for exactly one cycle; data_out/write_addr valid in that cycle; s_ready=0.
REQ-025 After WRITE: write_addr increments modulo 2^AW (63 -> 0 wrap); entry_count increments; lane counter and pack register cleared.
REQ-026 WRITE -> DONE if the entry contained s_last, or entry_count reaches 64 (overflow set in latter case); else -> FILL.
REQ-027 DONE: en_read=1 for one cycle, then IDLE; data_out retains last entry.
REQ-028 start while busy SHALL be ignored; s_valid in IDLE/WRITE/DONE SHALL NOT be consumed.
REQ-029 Latency: write_en asserts exactly one cycle after the completing beat's accepting edge; en_read one cycle after that write.
REQ-030 s_last with zero preceding beats in an entry is impossible (s_last qualifies an accepted beat); session with s_last on 64th entry sets no overflow.

Reset
REQ-031 rst=0 at a rising edge -> state IDLE; s_ready, write_en, en_read, busy, overflow = 0; data_out = 0; write_addr = 0; entry_count = 0.
REQ-032 Reset mid-session discards the partial entry; no write_en or en_read is issued for it.

Configuration
REQ-033 Macro VLOAD_BYTESWAP_EN: defined -> each accepted word is byte-reversed before packing (WORD_W multiple of 8); undefined -> word packed unchanged.

Verification
REQ-034 start, base_addr=1, 8 beats 0x00000000..0x00000007, last on 8th -> one write_en, write_addr=1, data_out lane k = k, en_read one cycle later, entry_count=1.
REQ-035 3 beats 0xAAAA0001..0xAAAA0003, last on 3rd -> data_out[95:0] holds words, [255:96]=0, write one cycle after 3rd beat.
REQ-036 base_addr=63, 16 beats, last on 16th -> writes at addr 63 then 0, entry_count=2, overflow=0.
REQ-037 base_addr=0, 512 beats, no s_last -> 64 writes, overflow=1, en_read pulse, s_ready=0 afterwards.
REQ-038 rst=0 after 5 beats -> no write_en/en_read, all outputs at reset values next cycle; new session packs from lane 0.
REQ-039 VLOAD_BYTESWAP_EN defined, one beat 0x12345678 with last -> data_out[31:0]=0x78563412.

Source files
------------

// File: rtl/vector_loader.sv
// Packs host words into SIZE-bit entries and issues one write strobe per entry, then an en_read pulse.
// Optional VLOAD_BYTESWAP_EN: byte-reverse each accepted word before packing.
module vector_loader #(
    parameter int WORD_W = 32,
    parameter int SIZE   = 256,
    parameter int AW     = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [AW-1:0]     base_addr,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    output logic [SIZE-1:0]   data_out,
    output logic [AW-1:0]     write_addr,
    output logic              write_en,
    output logic              en_read,
    output logic              busy,
    output logic [AW:0]       entry_count,
    output logic              overflow
);

    localparam int LANES = SIZE / WORD_W;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    state_t            r_state, w_state_nx;
    logic [SIZE-1:0]   r_pack, w_pack_nx, w_filled;
    logic [SIZE-1:0]   r_data, w_data_nx;
    logic [LW-1:0]     r_lane, w_lane_nx;
    logic              r_last, w_last_nx;
    logic [AW-1:0]     r_addr, w_addr_nx;
    logic [AW:0]       r_count, w_count_nx;
    logic              r_ovf, w_ovf_nx;
    logic              r_ready, w_ready_nx;
    logic              r_we, w_we_nx;
    logic              r_rd, w_rd_nx;
    logic              r_busy, w_busy_nx;
    logic [WORD_W-1:0] w_word;
    logic              w_beat;

`ifdef VLOAD_BYTESWAP_EN
    always_comb begin
        w_word = '0;
        for (int unsigned b = 0; b < WORD_W / 8; b++)
            w_word[b*8 +: 8] = s_data[WORD_W - 8 - b*8 +: 8];
    end
`else
    assign w_word = s_data;
`endif

    // r_ready is only ever high in FILL, so it alone qualifies a beat
    assign w_beat = r_ready & s_valid;

    always_comb begin
        w_filled = r_pack;
        w_filled[r_lane*WORD_W +: WORD_W] = w_word;
    end

    always_comb begin
        w_state_nx = r_state;
        w_pack_nx  = r_pack;
        w_data_nx  = r_data;
        w_lane_nx  = r_lane;
        w_last_nx  = r_last;
        w_addr_nx  = r_addr;
        w_count_nx = r_count;
        w_ovf_nx   = r_ovf;
        w_ready_nx = 1'b0;
        w_we_nx    = 1'b0;
        w_rd_nx    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_addr_nx  = base_addr;
                    w_count_nx = '0;
                    w_ovf_nx   = 1'b0;
                    w_lane_nx  = '0;
                    w_pack_nx  = '0;
                    w_last_nx  = 1'b0;
                    w_ready_nx = 1'b1;
                    w_state_nx = FILL;
                end
            end
            FILL: begin
                w_ready_nx = 1'b1;
                if (w_beat) begin
                    if (r_lane == LW'(LANES - 1) || s_last) begin
                        // pack/lane cleared here rather than after WRITE; nothing observes them in between
                        w_data_nx  = w_filled;
                        w_pack_nx  = '0;
                        w_lane_nx  = '0;
                        w_last_nx  = s_last;
                        w_we_nx    = 1'b1;
                        w_ready_nx = 1'b0;
                        w_state_nx = WRITE;
                    end else begin
                        w_pack_nx = w_filled;
                        w_lane_nx = LW'(r_lane + 1'b1);
                    end
                end
            end
            WRITE: begin
                w_addr_nx  = r_addr + 1'b1;
                w_count_nx = r_count + 1'b1;
                if (r_last || (r_count + 1'b1) == FULL) begin
                    w_ovf_nx   = ~r_last;
                    w_rd_nx    = 1'b1;
                    w_state_nx = DONE;
                end else begin
                    w_ready_nx = 1'b1;
                    w_state_nx = FILL;
                end
            end
            DONE: w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
        w_busy_nx = (w_state_nx != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_pack  <= '0;
            r_data  <= '0;
            r_lane  <= '0;
            r_last  <= 1'b0;
            r_addr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_ready <= 1'b0;
            r_we    <= 1'b0;
            r_rd    <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_pack  <= w_pack_nx;
            r_data  <= w_data_nx;
            r_lane  <= w_lane_nx;
            r_last  <= w_last_nx;
            r_addr  <= w_addr_nx;
            r_count <= w_count_nx;
            r_ovf   <= w_ovf_nx;
            r_ready <= w_ready_nx;
            r_we    <= w_we_nx;
            r_rd    <= w_rd_nx;
            r_busy  <= w_busy_nx;
        end
    end

    assign s_ready     = r_ready;
    assign data_out    = r_data;
    assign write_addr  = r_addr;
    assign write_en    = r_we;
    assign en_read     = r_rd;
    assign busy        = r_busy;
    assign entry_count = r_count;
    assign overflow    = r_ovf;

endmodule

// File: tb/tb_vector_loader.sv
// Directed self-checking bench for vector_loader (default parameters).
// Honours VLOAD_BYTESWAP_EN when the build defines it.
module tb_vector_loader;

    logic         clk = 1'b0;
    logic         rst, start, s_valid, s_last;
    logic [5:0]   base_addr;
    logic [31:0]  s_data;
    logic         s_ready, write_en, en_read, busy, overflow;
    logic [255:0] data_out;
    logic [5:0]   write_addr;
    logic [6:0]   entry_count;

    int n_cmp = 0;
    int n_fail = 0;
    int n_we = 0;
    int n_rd = 0;

    vector_loader #(.WORD_W(32), .SIZE(256), .AW(6)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .data_out(data_out), .write_addr(write_addr), .write_en(write_en),
        .en_read(en_read), .busy(busy), .entry_count(entry_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (write_en) n_we++;
        if (en_read)  n_rd++;
    end

    initial begin
        #1000000;
        $error("FAIL watchdog: observed timeout, expected completion");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [31:0] w);
`ifdef VLOAD_BYTESWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    task automatic start_session(input logic [5:0] base);
        start = 1'b1;
        base_addr = base;
        step();
        start = 1'b0;
    endtask

    // Holds the beat until an edge where s_ready was high; returns just after that edge.
    task automatic send_beat(input logic [31:0] d, input logic last);
        logic ok, rdy;
        ok = 1'b0;
        s_valid = 1'b1;
        s_data = d;
        s_last = last;
        for (int i = 0; i < 20; i++) begin
            rdy = s_ready;
            step();
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        s_valid = 1'b0;
        s_last = 1'b0;
        if (!ok) chk("beat_accept", {255'b0, ok}, 256'd1);
    endtask

    initial begin
        logic [255:0] e;
        int we0, rd0;

        rst = 1'b0; start = 1'b0; s_valid = 1'b0; s_last = 1'b0;
        base_addr = '0; s_data = '0;
        step(); step();
        chk("rst_ready", s_ready, 0);
        chk("rst_we", write_en, 0);
        chk("rst_rd", en_read, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_data", data_out, 0);
        chk("rst_addr", write_addr, 0);
        chk("rst_count", entry_count, 0);
        rst = 1'b1;
        step();

        // Full entry, 8 beats with last on the 8th
        start_session(6'd1);
        chk("t1_busy", busy, 1);
        chk("t1_ready", s_ready, 1);
        e = '0;
        for (int k = 0; k < 8; k++) begin
            send_beat(32'(k), k == 7);
            e[k*32 +: 32] = exp_word(32'(k));
            if (k == 3) chk("t1_no_we_mid", write_en, 0);
        end
        chk("t1_we", write_en, 1);
        chk("t1_addr", write_addr, 1);
        chk("t1_data", data_out, e);
        chk("t1_ready_write", s_ready, 0);
        step();
        chk("t1_rd", en_read, 1);
        chk("t1_we_off", write_en, 0);
        chk("t1_count", entry_count, 1);
        step();
        chk("t1_idle_busy", busy, 0);
        chk("t1_rd_off", en_read, 0);

        // Partial entry; a start during FILL must not relatch the address
        start_session(6'd5);
        start = 1'b1; base_addr = 6'd9;
        e = '0;
        for (int k = 0; k < 3; k++) begin
            send_beat(32'hAAAA0001 + 32'(k), k == 2);
            e[k*32 +: 32] = exp_word(32'hAAAA0001 + 32'(k));
        end
        start = 1'b0;
        chk("t2_we", write_en, 1);
        chk("t2_data", data_out, e);
        chk("t2_addr", write_addr, 5);
        step();
        chk("t2_rd", en_read, 1);
        chk("t2_ready_done", s_ready, 0);
        step();

        // Address wrap 63 -> 0 across two entries
        start_session(6'd63);
        for (int k = 0; k < 8; k++) send_beat(32'h100 + 32'(k), 1'b0);
        chk("t3_we0", write_en, 1);
        chk("t3_addr0", write_addr, 63);
        chk("t3_lane0", data_out[31:0], exp_word(32'h100));
        for (int k = 8; k < 16; k++) send_beat(32'h100 + 32'(k), k == 15);
        chk("t3_we1", write_en, 1);
        chk("t3_addr1", write_addr, 0);
        chk("t3_lane7", data_out[255:224], exp_word(32'h10F));
        step();
        chk("t3_rd", en_read, 1);
        chk("t3_count", entry_count, 2);
        chk("t3_ovf", overflow, 0);
        step();

        // 512 beats without last: 64 writes then overflow
        we0 = n_we; rd0 = n_rd;
        start_session(6'd0);
        for (int i = 0; i < 512; i++) send_beat(32'(i), 1'b0);
        chk("t4_we", write_en, 1);
        chk("t4_addr", write_addr, 63);
        chk("t4_lane0", data_out[31:0], exp_word(32'd504));
        chk("t4_lane7", data_out[255:224], exp_word(32'd511));
        step();
        chk("t4_rd", en_read, 1);
        chk("t4_ovf", overflow, 1);
        chk("t4_count", entry_count, 64);
        step();
        chk("t4_ready_after", s_ready, 0);
        chk("t4_busy_after", busy, 0);
        chk("t4_nwrites", 256'(n_we - we0), 64);
        chk("t4_nreads", 256'(n_rd - rd0), 1);

        // 64 entries with last on the final beat: no overflow
        start_session(6'd0);
        for (int i = 0; i < 512; i++) send_beat(32'(i), i == 511);
        step();
        chk("t5_rd", en_read, 1);
        chk("t5_count", entry_count, 64);
        chk("t5_ovf", overflow, 0);
        step();

        // Reset mid-session
        start_session(6'd7);
        for (int k = 0; k < 5; k++) send_beat(32'h500 + 32'(k), 1'b0);
        we0 = n_we; rd0 = n_rd;
        rst = 1'b0;
        step();
        chk("t6_ready", s_ready, 0);
        chk("t6_busy", busy, 0);
        chk("t6_data", data_out, 0);
        chk("t6_addr", write_addr, 0);
        chk("t6_count", entry_count, 0);
        chk("t6_we", write_en, 0);
        rst = 1'b1;
        step(); step();
        chk("t6_no_write", 256'(n_we - we0), 0);
        chk("t6_no_read", 256'(n_rd - rd0), 0);
        start_session(6'd2);
        send_beat(32'h0000_0011, 1'b1);
        e = '0;
        e[31:0] = exp_word(32'h0000_0011);
        chk("t6_new_data", data_out, e);
        chk("t6_new_addr", write_addr, 2);
        step(); step();

`ifdef VLOAD_BYTESWAP_EN
        start_session(6'd0);
        send_beat(32'h12345678, 1'b1);
        chk("t7_swap", data_out[31:0], 32'h78563412);
        step(); step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
